// File: rtl/modexp_operand_feeder_pkg.sv
// ---- modexp_operand_feeder_pkg : shared width, defaults and FSM encoding (rev 1.0) ----
`default_nettype none
package modexp_operand_feeder_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int NUM_WORDS_DEFAULT  = 128;

  typedef enum logic [2:0] {
    FILL    = 3'd0,
    START   = 3'd1,
    STREAM  = 3'd2,
    GAP     = 3'd3,
    COMPUTE = 3'd4,
    RESULT  = 3'd5
  } feeder_state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/modexp_operand_feeder_if.sv
// ---- modexp_operand_feeder_if : host word handshake plus result-release strobe (rev 1.0) ----
`default_nettype none
interface modexp_operand_feeder_if
  import modexp_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) ();

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  host_release;

  modport master (output in_data, output in_valid, output host_release, input in_ready);
  modport slave  (input in_data, input in_valid, input host_release, output in_ready);

endinterface
`default_nettype wire

// File: rtl/modexp_word_ram.sv
// ---- modexp_word_ram : simple dual-port RAM, registered read that clears when idle (rev 1.0) ----
`default_nettype none
module modexp_word_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = 7
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  wr_en,
  input  wire logic [ADDR_W-1:0]     wr_addr,
  input  wire logic [DATA_WIDTH-1:0] wr_data,
  input  wire logic                  rd_en,
  input  wire logic [ADDR_W-1:0]     rd_addr,
  output logic      [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read register doubles as the operand output, so it reads zero whenever not streaming.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end

endmodule
`default_nettype wire

// File: rtl/modexp_operand_feeder.sv
// ---- modexp_operand_feeder : buffers a host operand frame and replays it to ModExp (rev 1.0) ----
`default_nettype none
module modexp_operand_feeder
  import modexp_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  parameter int NUM_WORDS    = NUM_WORDS_DEFAULT,
  parameter int GAP_CYCLES   = 2,
  parameter int RESULT_DELAY = 100
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  modexp_operand_feeder_if.slave     host,
  output logic                       startInput,
  output logic      [DATA_WIDTH-1:0] inp,
  output logic                       startCompute,
  output logic                       getResult,
  output logic                       busy
);

  localparam int PTR_W   = ptr_width(NUM_WORDS);
  localparam int CNT_MAX = (NUM_WORDS > GAP_CYCLES)
                         ? ((NUM_WORDS > RESULT_DELAY) ? NUM_WORDS : RESULT_DELAY)
                         : ((GAP_CYCLES > RESULT_DELAY) ? GAP_CYCLES : RESULT_DELAY);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(RESULT_DELAY - 1);

  feeder_state_e    state, next_state;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             wr_fire;
  logic             rd_en;
  logic             frame_end;

  assign wr_fire   = (state == FILL) && host.in_valid && host.in_ready;
  // Reads run one cycle ahead of inp: address 0 in START, then k+1 while word k is shown.
  assign rd_en     = (state == START) || ((state == STREAM) && (cnt != LAST_WORD));
  assign frame_end = (state == RESULT) && host.host_release;

  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (wr_fire && (wr_ptr == LAST_PTR)) next_state = START;
      START:   next_state = STREAM;
      STREAM:  if (cnt == LAST_WORD) next_state = (GAP_CYCLES == 0) ? COMPUTE : GAP;
      GAP:     if (cnt == GAP_LAST) next_state = COMPUTE;
      COMPUTE: if (cnt == DELAY_LAST) next_state = RESULT;
      RESULT:  if (host.host_release) next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FILL;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      host.in_ready <= 1'b1;
      startInput    <= 1'b0;
      startCompute  <= 1'b0;
      getResult     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= next_state;

      if (frame_end)                                wr_ptr <= '0;
      else if (wr_fire && (wr_ptr != LAST_PTR))     wr_ptr <= wr_ptr + 1'b1;

      if (frame_end)                                rd_ptr <= '0;
      else if (rd_en && (rd_ptr != LAST_PTR))       rd_ptr <= rd_ptr + 1'b1;

      if (next_state != state)                      cnt <= '0;
      else if ((state == STREAM) || (state == GAP) || (state == COMPUTE))
                                                    cnt <= cnt + 1'b1;

      host.in_ready <= (next_state == FILL);
      startInput    <= (next_state == START);
      startCompute  <= (next_state == COMPUTE) || (next_state == RESULT);
      getResult     <= (next_state == RESULT);
      busy          <= (next_state != FILL);
    end
  end

  modexp_word_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_WORDS),
    .ADDR_W     (PTR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (host.in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (inp)
  );

endmodule
`default_nettype wire

// File: tb/tb_modexp_operand_feeder.sv
// ---- tb_modexp_operand_feeder : directed self-checking bench for the operand feeder (rev 1.0) ----
`default_nettype none
module tb_modexp_operand_feeder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  modexp_operand_feeder_if #(.DATA_WIDTH(32)) ha ();
  modexp_operand_feeder_if #(.DATA_WIDTH(32)) hb ();

  logic        a_start, a_comp, a_get, a_busy;
  logic [31:0] a_inp;
  logic        b_start, b_comp, b_get, b_busy;
  logic [31:0] b_inp;

  modexp_operand_feeder #(.DATA_WIDTH(32), .NUM_WORDS(128), .GAP_CYCLES(2), .RESULT_DELAY(100)) dut_a (
    .clk(clk), .reset(reset), .host(ha), .startInput(a_start), .inp(a_inp),
    .startCompute(a_comp), .getResult(a_get), .busy(a_busy));

  modexp_operand_feeder #(.DATA_WIDTH(32), .NUM_WORDS(4), .GAP_CYCLES(2), .RESULT_DELAY(5)) dut_b (
    .clk(clk), .reset(reset), .host(hb), .startInput(b_start), .inp(b_inp),
    .startCompute(b_comp), .getResult(b_get), .busy(b_busy));

  int checks   = 0;
  int failures = 0;

  logic [31:0] wa [128];
  logic [31:0] wc [128];
  logic [31:0] wd [128];
  int          vseq [7] = '{1, 0, 0, 1, 1, 0, 1};
  logic [31:0] dseq [7] = '{32'h11, 32'hBAD0BAD0, 32'hBAD1BAD1, 32'h22, 32'h33, 32'hBAD2BAD2, 32'h44};
  logic [31:0] bw   [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 128; k++) begin
      wa[k] = 32'hc8803b31 ^ (k * 32'h9E3779B9);
      wc[k] = 32'h5A000000 + k * 3;
      wd[k] = 32'h0F000000 | (k << 8) | (127 - k);
    end
    wa[0]   = 32'hc8803b31;
    wa[127] = 32'h25f49f66;

    reset = 1'b1;
    ha.in_valid = 1'b0; ha.in_data = '0; ha.host_release = 1'b0;
    hb.in_valid = 1'b0; hb.in_data = '0; hb.host_release = 1'b0;
    tick(); tick(); tick();
    chk("rst_in_ready", ha.in_ready, 1);
    chk("rst_start",    a_start, 0);
    chk("rst_inp",      a_inp, 0);
    chk("rst_comp",     a_comp, 0);
    chk("rst_get",      a_get, 0);
    chk("rst_busy",     a_busy, 0);
    chk("rst_b_ready",  hb.in_ready, 1);
    reset = 1'b0;
    tick();

    // ---- full 128-word frame on A, host keeps pushing during STREAM ----
    for (int k = 0; k < 128; k++) begin
      ha.in_valid = 1'b1; ha.in_data = wa[k];
      tick();
    end
    ha.in_data = 32'hDEADBEEF;
    chk("a_start_pulse", a_start, 1);
    chk("a_busy_start",  a_busy, 1);
    chk("a_inp_start",   a_inp, 0);
    tick();
    chk("a_start_once",  a_start, 0);
    for (int k = 0; k < 128; k++) begin
      chk("a_stream", a_inp, wa[k]);
      chk("a_ready_low", ha.in_ready, 0);
      tick();
    end
    ha.in_valid = 1'b0;
    chk("a_gap0_inp",  a_inp, 0);
    chk("a_gap0_comp", a_comp, 0);
    tick();
    chk("a_gap1_comp", a_comp, 0);
    tick();
    chk("a_comp_rise", a_comp, 1);
    chk("a_get_early", a_get, 0);
    for (int c = 133; c < 232; c++) begin
      tick();
      ha.host_release = (c == 150);
      if (c == 152) chk("a_rel_compute_ignored", a_comp, 1);
    end
    chk("a_get_before", a_get, 0);
    tick();
    chk("a_get_rise",  a_get, 1);
    chk("a_comp_hold", a_comp, 1);
    tick(); tick(); tick();
    chk("a_get_held", a_get, 1);
    ha.host_release = 1'b1;
    tick();
    ha.host_release = 1'b0;
    chk("a_rel_get",   a_get, 0);
    chk("a_rel_comp",  a_comp, 0);
    chk("a_rel_ready", ha.in_ready, 1);
    chk("a_rel_busy",  a_busy, 0);

    // ---- B: host stalls while filling a 4-word frame ----
    for (int i = 0; i < 7; i++) begin
      chk("b_ready_fill", hb.in_ready, 1);
      hb.in_valid = vseq[i][0]; hb.in_data = dseq[i];
      tick();
    end
    hb.in_valid = 1'b1; hb.in_data = 32'hDEADBEEF;
    chk("b_start", b_start, 1);
    chk("b_ready_low", hb.in_ready, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("b_stream", b_inp, bw[k]);
      tick();
    end
    hb.in_valid = 1'b0;
    chk("b_gap_inp", b_inp, 0);
    tick();
    chk("b_gap_comp", b_comp, 0);
    tick();
    chk("b_comp_rise", b_comp, 1);
    tick(); tick(); tick(); tick();
    chk("b_get_before", b_get, 0);
    tick();
    chk("b_get_rise", b_get, 1);
    hb.host_release = 1'b1;
    tick();
    hb.host_release = 1'b0;
    chk("b_rel_first_get",  b_get, 0);
    chk("b_rel_first_comp", b_comp, 0);
    chk("b_rel_first_rdy",  hb.in_ready, 1);

    // ---- B: second frame after release, release during GAP ignored ----
    for (int k = 0; k < 4; k++) begin
      hb.in_valid = 1'b1; hb.in_data = 32'hA0 + k;
      tick();
    end
    hb.in_valid = 1'b0;
    chk("b2_start", b_start, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("b2_stream", b_inp, 32'hA0 + k);
      tick();
    end
    hb.host_release = 1'b1;
    tick();
    hb.host_release = 1'b0;
    chk("b2_gap_rel_busy", b_busy, 1);
    tick();
    chk("b2_comp_rise", b_comp, 1);
    tick(); tick(); tick(); tick(); tick();
    chk("b2_get_rise", b_get, 1);
    tick(); tick();
    chk("b2_get_held", b_get, 1);
    hb.host_release = 1'b1;
    tick();
    hb.host_release = 1'b0;
    chk("b2_rel_get",  b_get, 0);
    chk("b2_rel_rdy",  hb.in_ready, 1);

    // ---- A: reset in the middle of STREAM, then a fresh frame ----
    for (int k = 0; k < 128; k++) begin
      ha.in_valid = 1'b1; ha.in_data = wc[k];
      tick();
    end
    ha.in_valid = 1'b0;
    tick();
    for (int k = 0; k <= 50; k++) begin
      chk("c_stream", a_inp, wc[k]);
      if (k < 50) tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("c_rst_inp",   a_inp, 0);
    chk("c_rst_ready", ha.in_ready, 1);
    chk("c_rst_busy",  a_busy, 0);
    chk("c_rst_start", a_start, 0);
    for (int k = 0; k < 128; k++) begin
      ha.in_valid = 1'b1; ha.in_data = wd[k];
      tick();
    end
    ha.in_valid = 1'b0;
    chk("d_start", a_start, 1);
    tick();
    for (int k = 0; k < 128; k++) begin
      chk("d_stream", a_inp, wd[k]);
      tick();
    end
    chk("d_gap_inp", a_inp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/modexp_operand_feeder.md
Name: modexp_operand_feeder

Overview:
- Upstream stage of ModExp.
- Accepts the 4096-bit operand from a host as 32-bit words over a valid/ready handshake and buffers a complete frame.
- Replays the frame to ModExp using its native protocol:
  - a startInput pulse, then one word per cycle on inp;
  - a fixed idle gap, then startCompute held high;
  - after a programmable delay, getResult.
- Host side and ModExp side are decoupled, so the host may stall freely.

Parameters:
- DATA_WIDTH, 32: word width; equals the shared `DATA_WIDTH.
- NUM_WORDS, 128: words per operand frame (4096/32).
- GAP_CYCLES, 2: idle cycles between the last streamed word and startCompute rising.
- RESULT_DELAY, 100: cycles startCompute is high before getResult rises.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  host operand word; word 0 is first.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts a word this cycle; transfer when in_valid&&in_ready.
- release  in  1  host pulse: result has been consumed; ends the frame.
- startInput  out  1  one-cycle pulse to ModExp.
- inp  out  DATA_WIDTH  operand word to ModExp.
- startCompute  out  1  level to ModExp.
- getResult  out  1  level to ModExp.
- busy  out  1  high in every state except FILL.

Behaviour:
- Reset values:
  - state=FILL; wr_ptr=0, rd_ptr=0, cnt=0.
  - in_ready=1, startInput=0, inp=0, startCompute=0, getResult=0, busy=0.
  - Reset mid-operation aborts the frame immediately, returns to these values, and discards buffered words.
- Buffer:
  - NUM_WORDS x DATA_WIDTH RAM; write port from the host, read port to inp.
  - Pointers are clog2(NUM_WORDS) bits wide.
  - The buffer is never written outside FILL.
- All outputs are registered.
- FSM states and transitions:
  - FILL:
    - in_ready=1; each transfer writes RAM[wr_ptr] and increments wr_ptr.
    - The transfer of word NUM_WORDS-1 (buffer full) moves to START; in_ready=0 from the next cycle.
    - in_valid with in_ready=0 is ignored; no word is lost or duplicated.
  - START: startInput=1 for exactly one cycle; inp=0; rd_ptr=0; then STREAM.
  - STREAM:
    - inp=RAM[rd_ptr] on NUM_WORDS consecutive cycles, in arrival order, no bubbles.
    - After word NUM_WORDS-1, go to GAP.
  - GAP: inp=0 for GAP_CYCLES cycles; then COMPUTE.
    - GAP_CYCLES=0 goes directly to COMPUTE.
  - COMPUTE: startCompute=1; cnt counts RESULT_DELAY cycles; then RESULT.
  - RESULT:
    - startCompute=1 and getResult=1, held until release.
    - On release: both drop the next cycle, pointers clear, state=FILL.
- Timing, with the last host transfer at edge T:
  - startInput high in cycle T+1.
  - Word k on inp in cycle T+2+k.
  - startCompute rises at T+2+NUM_WORDS+GAP_CYCLES.
  - getResult rises RESULT_DELAY cycles after that.
- Boundary conditions:
  - release outside RESULT is ignored.
  - release arriving in the same cycle that RESULT is entered is honoured on the following cycle.
  - wr_ptr and rd_ptr never wrap mid-frame; they are cleared only on frame end or reset.
  - NUM_WORDS=1 is legal: START is followed by a single STREAM cycle.

Decomposition:
- Shared package/include (`_parameter.v`):
  - `DATA_WIDTH.
  - NUM_WORDS default.
  - FSM state encodings: FILL, START, STREAM, GAP, COMPUTE, RESULT (3-bit).
- One sub-module: modexp_word_ram, a simple dual-port synchronous RAM (1 write, 1 read, registered read).
  - Its one-cycle read latency is absorbed by issuing the read address during START.

Test Plan:
- Reset/idle:
  - Hold reset 3 cycles -> all outputs 0 except in_ready=1; busy=0.
- Full frame, NUM_WORDS=128, GAP_CYCLES=2, RESULT_DELAY=100, host words 0xc8803b31..0x25f49f66 back-to-back:
  - startInput pulses once at T+1.
  - inp shows 0xc8803b31 at T+2 and 0x25f49f66 at T+129.
  - startCompute rises at T+132; getResult rises at T+232.
- Host stalls, NUM_WORDS=4, in_valid toggling 1,0,0,1,1,0,1 with words 0x11,0x22,0x33,0x44:
  - Exactly 4 words accepted; inp stream is 0x11,0x22,0x33,0x44 contiguous.
- Backpressure:
  - Hold in_valid=1 with word 0xDEADBEEF throughout STREAM -> in_ready=0, the buffer is unchanged, and the stream matches the original frame.
- Release handling:
  - release pulsed during COMPUTE -> ignored.
  - release pulsed in RESULT -> startCompute and getResult drop the next cycle; in_ready=1; a second frame 0xA0..0xA3 streams correctly.
- Reset mid-STREAM after word 50:
  - Next cycle: inp=0, state FILL, in_ready=1.
  - A new frame loads from word 0 with no stale data.
